// File: rtl/conv_row_engine.sv
// 1D convolution row engine: loads KSIZE weights and a ROW_LEN activation row, then streams
// one signed partial sum per output position (stride 1 or 2). Define CONV_ROW_RELU_EN to clamp negative sums to zero.
module conv_row_engine #(
   parameter int DATA_W  = 8,
   parameter int ROW_LEN = 16,
   parameter int KSIZE   = 3,
   parameter int PAD     = 1,
   parameter int ACC_W   = 2*DATA_W+$clog2(KSIZE)+1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     cfg_stride2,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_psum,
   output logic                     out_last,
   output logic                     busy
);

   localparam int OUT_LEN1 = (ROW_LEN + 2*PAD - KSIZE) + 1;
   localparam int OUT_LEN2 = (ROW_LEN + 2*PAD - KSIZE)/2 + 1;
   localparam int JW = $clog2(OUT_LEN1 + 1);
   localparam int CW = $clog2(ROW_LEN + 1);
   localparam int XW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam int PW = 2*DATA_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_W  = 3'd1,
      LOAD_A  = 3'd2,
      COMPUTE = 3'd3,
      HOLD    = 3'd4
   } state_t;

   state_t                    state_r, state_s;
   logic signed [DATA_W-1:0]  w_r [KSIZE];
   logic signed [DATA_W-1:0]  x_r [ROW_LEN];
   logic [CW-1:0]             cnt_r;
   logic [JW-1:0]             j_r;
   logic                      stride_r;
   logic                      in_ready_r, out_valid_r, out_last_r, busy_r;
   logic signed [ACC_W-1:0]   out_psum_r;
   logic                      in_hs_s, out_hs_s;
   logic [JW-1:0]             last_j_s;
   int                        idx_s;
   logic signed [PW-1:0]      prod_s;
   logic signed [ACC_W-1:0]   sum_s, psum_s;

   assign in_hs_s  = in_valid & in_ready_r;
   assign out_hs_s = out_valid_r & out_ready;
   assign last_j_s = stride_r ? JW'(OUT_LEN2 - 1) : JW'(OUT_LEN1 - 1);

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_hs_s) state_s = (KSIZE == 1) ? LOAD_A : LOAD_W;
            else         state_s = IDLE;
         end
         LOAD_W: begin
            if (in_hs_s && cnt_r == CW'(KSIZE - 1)) state_s = LOAD_A;
            else                                     state_s = LOAD_W;
         end
         LOAD_A: begin
            if (in_hs_s && cnt_r == CW'(ROW_LEN - 1)) state_s = COMPUTE;
            else                                       state_s = LOAD_A;
         end
         COMPUTE: state_s = HOLD;
         HOLD: begin
            if (out_hs_s) state_s = (j_r == last_j_s) ? IDLE : COMPUTE;
            else          state_s = HOLD;
         end
         default: state_s = IDLE;
      endcase
   end

   // Window dot product; taps falling in the padding read as zero
   always_comb begin
      sum_s  = '0;
      idx_s  = 0;
      prod_s = '0;
      for (int k = 0; k < KSIZE; k++) begin
         idx_s = (stride_r ? 2*int'(j_r) : int'(j_r)) + k - PAD;
         if (idx_s >= 0 && idx_s < ROW_LEN) begin
            prod_s = PW'(w_r[k[KW-1:0]]) * PW'(x_r[idx_s[XW-1:0]]);
         end else begin
            prod_s = '0;
         end
         sum_s = sum_s + ACC_W'(prod_s);
      end
   end

`ifdef CONV_ROW_RELU_EN
   assign psum_s = sum_s[ACC_W-1] ? '0 : sum_s;
`else
   assign psum_s = sum_s;
`endif

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_r <= IDLE;
      else       state_r <= state_s;
   end

   // Load buffers, output register and position counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < KSIZE; k++)   w_r[k] <= '0;
         for (int i = 0; i < ROW_LEN; i++) x_r[i] <= '0;
         cnt_r       <= '0;
         j_r         <= '0;
         stride_r    <= 1'b0;
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_psum_r  <= '0;
      end else begin
         in_ready_r <= (state_s == IDLE) || (state_s == LOAD_W) || (state_s == LOAD_A);
         busy_r     <= (state_s != IDLE);
         case (state_r)
            IDLE: if (in_hs_s) begin
               w_r[0]   <= in_data;
               stride_r <= cfg_stride2;
               cnt_r    <= (KSIZE == 1) ? CW'(0) : CW'(1);
            end
            LOAD_W: if (in_hs_s) begin
               w_r[cnt_r[KW-1:0]] <= in_data;
               cnt_r <= (cnt_r == CW'(KSIZE - 1)) ? CW'(0) : cnt_r + CW'(1);
            end
            LOAD_A: if (in_hs_s) begin
               x_r[cnt_r[XW-1:0]] <= in_data;
               if (cnt_r == CW'(ROW_LEN - 1)) begin
                  cnt_r <= '0;
                  j_r   <= '0;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            COMPUTE: begin
               out_psum_r  <= psum_s;
               out_valid_r <= 1'b1;
               out_last_r  <= (j_r == last_j_s);
            end
            HOLD: if (out_hs_s) begin
               out_valid_r <= 1'b0;
               j_r <= (j_r == last_j_s) ? JW'(0) : j_r + JW'(1);
            end
            default: out_valid_r <= 1'b0;
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_psum  = out_psum_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_conv_row_engine.sv
// Self-checking bench for conv_row_engine: directed rows checked against an arithmetic
// convolution model plus hand-computed literal output lists.
module tb_conv_row_engine;
   localparam int DATA_W  = 8;
   localparam int ROW_LEN = 16;
   localparam int KSIZE   = 3;
   localparam int PAD     = 1;
   localparam int ACC_W   = 2*DATA_W+$clog2(KSIZE)+1;

   logic clk = 1'b0, rstn = 1'b0, cfg_stride2 = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, out_last, busy;
   logic signed [DATA_W-1:0] in_data = '0;
   logic signed [ACC_W-1:0]  out_psum;

   int nvec = 0, nerr = 0, ready_mode = 0, cyc = 0;
   longint exp_q[$];
   bit     last_q[$];
   longint cap[$];
   logic   prev_stall = 1'b0, prev_last = 1'b0;
   logic signed [ACC_W-1:0] prev_psum = '0;

   always #5 clk = ~clk;

   conv_row_engine #(.DATA_W(DATA_W), .ROW_LEN(ROW_LEN), .KSIZE(KSIZE), .PAD(PAD), .ACC_W(ACC_W)) dut (
      .clk(clk), .rstn(rstn), .cfg_stride2(cfg_stride2), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
      .out_last(out_last), .busy(busy));

   task automatic chk(input string name, input longint act, input longint exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: direct evaluation of the convolution sum with zero padding
   task automatic model_row(input int w[KSIZE], input int x[ROW_LEN], input bit s2);
      int st = s2 ? 2 : 1;
      int n  = (ROW_LEN + 2*PAD - KSIZE)/st + 1;
      for (int j = 0; j < n; j++) begin
         longint s = 0;
         for (int k = 0; k < KSIZE; k++) begin
            int idx = st*j + k - PAD;
            if (idx >= 0 && idx < ROW_LEN) s += longint'(w[k]) * longint'(x[idx]);
         end
`ifdef CONV_ROW_RELU_EN
         if (s < 0) s = 0;
`endif
         exp_q.push_back(s);
         last_q.push_back(j == n-1);
      end
   endtask

   // Output monitor: drives out_ready, checks handshakes and stall stability
   always @(negedge clk) begin
      cyc++;
      out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (rstn) begin
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_psum", out_psum, prev_psum);
            chk("stall_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL extra_output: got psum %0d, expected none", out_psum);
            end else begin
               chk("psum", out_psum, exp_q[0]);
               chk("last", out_last, longint'(last_q[0]));
               void'(exp_q.pop_front());
               void'(last_q.pop_front());
            end
            cap.push_back(out_psum);
         end
         prev_stall = out_valid && !out_ready;
         prev_psum  = out_psum;
         prev_last  = out_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic send(input int d);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d[DATA_W-1:0];
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      if (!in_ready) begin
         nvec++; nerr++;
         $display("FAIL in_ready_timeout: got 0, expected 1");
      end
      @(negedge clk);
   endtask

   task automatic run_row(input int w[KSIZE], input int x[ROW_LEN], input bit s2, input bit gap,
                          input int exp_cycles);
      int t = 1;
      cap.delete();
      model_row(w, x, s2);
      cfg_stride2 = s2;
      for (int k = 0; k < KSIZE; k++) begin
         send(w[k]);
         cfg_stride2 = ~s2;
      end
      for (int i = 0; i < ROW_LEN; i++) begin
         send(x[i]);
         if (gap && (i % 5 == 2)) begin in_valid = 1'b0; @(negedge clk); end
      end
      in_valid = 1'b0;
      chk("lat_compute_cycle", out_valid, 0);
      @(negedge clk);
      chk("lat_first_valid", out_valid, 1);
      while (!in_ready && t < 2000) begin @(negedge clk); t++; end
      if (exp_cycles > 0) chk("row_cycles", t, exp_cycles);
      chk("row_drained", exp_q.size(), 0);
   endtask

   task automatic chk_cap(input string name, input longint e[ROW_LEN], input int n);
      chk({name, "_count"}, cap.size(), n);
      for (int i = 0; i < n; i++) chk(name, (i < cap.size()) ? cap[i] : -999999, e[i]);
   endtask

   initial begin
      int w[KSIZE];
      int x[ROW_LEN];
      longint e[ROW_LEN];
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_psum", out_psum, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_busy", busy, 0);

      // stride 2, all ones
      w = '{1, 1, 1};
      x = '{default: 1};
      run_row(w, x, 1'b1, 1'b0, 16);
      e = '{default: 3}; e[0] = 2;
      chk_cap("s2_ones", e, 8);

      // stride 1, all ones, with input gaps
      run_row(w, x, 1'b0, 1'b1, 32);
      e = '{default: 3}; e[0] = 2; e[15] = 2;
      chk_cap("s1_ones", e, 16);

      // most negative operands, no overflow
      w = '{-128, -128, -128};
      x = '{default: -128};
      run_row(w, x, 1'b1, 1'b0, 16);
      e = '{default: 49152}; e[0] = 32768;
      chk_cap("s2_min", e, 8);

      // backpressure 1-0-0-1 in stride 1 with mixed-sign data
      ready_mode = 1;
      w = '{1, -2, 3};
      for (int i = 0; i < ROW_LEN; i++) x[i] = i*7 - 50;
      run_row(w, x, 1'b0, 1'b0, 0);
      ready_mode = 0;
      @(negedge clk);

      // reset pulse after 10 load beats
      cfg_stride2 = 1'b1;
      for (int i = 0; i < 10; i++) send(i + 1);
      in_valid = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("after_pulse_busy", busy, 0);
      chk("after_pulse_in_ready", in_ready, 1);
      w = '{1, 0, 0};
      for (int i = 0; i < ROW_LEN; i++) x[i] = i;
      run_row(w, x, 1'b1, 1'b0, 16);
      e = '{default: 0};
      for (int i = 1; i < 8; i++) e[i] = 2*i - 1;
      chk_cap("after_rst_row", e, 8);

      // negative sums, raw or clamped
      w = '{-1, 0, 0};
      x = '{default: 5};
      run_row(w, x, 1'b0, 1'b0, 32);
`ifdef CONV_ROW_RELU_EN
      e = '{default: 0};
`else
      e = '{default: -5}; e[0] = 0;
`endif
      chk_cap("neg_row", e, 16);

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
